doorlock_ctrl: RTL and testbench
================================

DOORLOCK_CTRL -- requirements
Module: doorlock_ctrl

Interface
REQ-001 SHALL have parameter UNLOCK_CYCLES, default 50_000_000: cycles the door stays unlocked after a correct code.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 150_000_000: cycles of keypad lockout after MAX_FAIL failures.
REQ-003 SHALL have parameter MAX_FAIL, default 3: consecutive wrong codes that trigger lockout (range 1..7).
REQ-004 SHALL have parameter DEFAULT_PW, default 16'h1234: stored code after reset, most significant nibble = first digit.
REQ-005 SHALL provide these ports (clock and reset first); clock and reset names follow codebase convention; one clock; reset asynchronous, active-high:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0-9 digit; 4'hA CLEAR; 4'hB ENTER; 4'hC CHANGE; others ignored.
- unlocked  out  1  door actuator enable.
- locked_out  out  1  keypad lockout active.
- digit_cnt  out  3  digits captured in the current entry (0..4).
- fail_cnt  out  3  consecutive failures.
- change_mode  out  1  waiting for a new 4-digit code.
- err_pulse  out  1  one-cycle pulse when an entry is rejected.

Function
REQ-006 SHALL implement states IDLE, ENTRY, CHECK, OPEN, NEWPW, LOCKOUT.
REQ-007 SHALL, in IDLE/ENTRY, shift each digit into a 4-nibble entry buffer (first digit ends in MSN) and increment digit_cnt; a 5th+ digit is ignored, with digit_cnt held at 4.
REQ-008 SHALL, on CLEAR in ENTRY/NEWPW, zero the buffer and digit_cnt, return to IDLE, clear change_mode, and leave fail_cnt unchanged.
REQ-009 SHALL, on ENTER with digit_cnt==4, go to CHECK for exactly one cycle and compare all 4 nibbles against the stored code.
REQ-010 SHALL, on ENTER with digit_cnt<4, pulse err_pulse, count a failure, and clear the buffer.
REQ-011 SHALL, on a match in CHECK, clear fail_cnt, enter OPEN, and assert unlocked from the next cycle for exactly UNLOCK_CYCLES cycles, then return to IDLE.
REQ-012 SHALL, on a mismatch, pulse err_pulse in the cycle after CHECK and increment fail_cnt; when fail_cnt reaches MAX_FAIL, enter LOCKOUT, else IDLE.
REQ-013 SHALL, in LOCKOUT, assert locked_out, ignore all keys for LOCKOUT_CYCLES cycles, then clear fail_cnt and return to IDLE.
REQ-014 SHALL, on CHANGE in OPEN, enter NEWPW, deassert unlocked immediately, assert change_mode, and clear the buffer.
REQ-015 SHALL, in NEWPW, capture digits as in REQ-007; ENTER with 4 digits writes the buffer to the stored code and returns to IDLE; ENTER with fewer than 4 pulses err_pulse and stays in NEWPW without counting a failure.
REQ-016 SHALL ignore keys in OPEN other than CHANGE, and ignore CHANGE outside OPEN.
REQ-017 SHALL ignore key_valid during CHECK; timers SHALL be single down-counters, sized by $clog2 of the larger parameter, and SHALL not wrap.
REQ-018 SHALL register all outputs, drive no combinational path from key inputs to outputs, and keep err_pulse exactly 1 cycle.

Reset
REQ-019 SHALL, on rst, asynchronously force IDLE, stored code=DEFAULT_PW, buffer=0, and timers=0.
REQ-020 SHALL, on rst, drive unlocked=0, locked_out=0, digit_cnt=0, fail_cnt=0, change_mode=0, and err_pulse=0.
REQ-021 SHALL, on reset mid-OPEN/LOCKOUT/NEWPW, abort immediately with the reset values; a code change in progress is lost and DEFAULT_PW is restored.

Structure
REQ-022 SHALL place the state enum, key code constants (KEY_CLEAR, KEY_ENTER, KEY_CHANGE), and the digit count width in the shared package doorlock_pkg.
REQ-023 SHALL instantiate one sub-module, doorlock_pw_cmp: combinational 4-nibble equality, 16-bit entry and 16-bit stored code in, 1-bit match out.

Verification
REQ-024 SHALL cover correct code: keys 1,2,3,4,ENTER -> CHECK for 1 cycle; unlocked=1 for UNLOCK_CYCLES (e.g. 20) cycles, then 0; fail_cnt=0.
REQ-025 SHALL cover lockout: 3x (9,9,9,9,ENTER) with MAX_FAIL=3 -> err_pulse three times; locked_out=1 for LOCKOUT_CYCLES; keys ignored during lockout; fail_cnt=0 afterwards.
REQ-026 SHALL cover code change: open, CHANGE, 5,6,7,8,ENTER -> change_mode 1 then 0; afterwards 1,2,3,4 fails and 5,6,7,8 unlocks.
REQ-027 SHALL cover boundaries: 1,2,CLEAR,1,2,3,4,5,ENTER -> 5th digit ignored, unlock; 1,2,ENTER -> err_pulse, fail_cnt=1.
REQ-028 SHALL cover reset: rst asserted mid-OPEN and mid-NEWPW (after 2 digits) -> all outputs 0 asynchronously; 1,2,3,4 unlocks afterwards.

Source files
------------

// File: rtl/doorlock_pkg.sv
// Shared types and constants for the door lock keypad controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package doorlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    NEWPW,
    LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  localparam int DIGIT_CNT_W = 3;
  localparam logic [DIGIT_CNT_W-1:0] DIGITS_FULL = DIGIT_CNT_W'(4);

  // Keys 0..9 are digits; A..C are commands; D..F are ignored.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/doorlock_pw_cmp.sv
// Compares the 4-nibble keypad entry against the stored code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; always produces a result.
module doorlock_pw_cmp (
  input  logic [15:0] entry,
  input  logic [15:0] stored,
  output logic        match
);

  logic [3:0] nib_eq;

  // Per-digit equality so a mismatch in any position rejects the code.
  always_comb begin
    nib_eq = '0;
    for (int i = 0; i < 4; i++) begin
      nib_eq[i] = (entry[4*i +: 4] == stored[4*i +: 4]);
    end
  end

  assign match = &nib_eq;

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door lock: code entry, unlock window, code change and failure lockout.
// Latency: outputs registered, one cycle after the key strobe; code check takes one extra cycle.
// Backpressure: none; keys arriving in CHECK, OPEN (except CHANGE) or LOCKOUT are dropped.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int          UNLOCK_CYCLES  = 50_000_000,
  parameter int          LOCKOUT_CYCLES = 150_000_000,
  parameter int          MAX_FAIL       = 3,
  parameter logic [15:0] DEFAULT_PW     = 16'h1234
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   unlocked,
  output logic                   locked_out,
  output logic [DIGIT_CNT_W-1:0] digit_cnt,
  output logic [2:0]             fail_cnt,
  output logic                   change_mode,
  output logic                   err_pulse
);

  // One shared down-counter serves both the unlock window and the lockout.
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  // Loaded with N-1: the output is set on the loading edge and cleared on the edge that sees zero.
  localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       MAX_FAIL_C   = 3'(MAX_FAIL);

  state_t           state;
  logic [15:0]      entry_buf;
  logic [15:0]      stored_pw;
  logic [TMR_W-1:0] timer;
  logic             pw_match;

  logic             key_dig;
  logic             key_clr;
  logic             key_ent;
  logic             key_chg;
  logic             buf_full;
  logic [2:0]       fail_inc;
  logic             fail_trip;

  assign key_dig   = key_valid && is_digit(key_code);
  assign key_clr   = key_valid && (key_code == KEY_CLEAR);
  assign key_ent   = key_valid && (key_code == KEY_ENTER);
  assign key_chg   = key_valid && (key_code == KEY_CHANGE);
  assign buf_full  = (digit_cnt == DIGITS_FULL);
  // fail_cnt stays below MAX_FAIL outside LOCKOUT, so the increment cannot overflow.
  assign fail_inc  = fail_cnt + 3'd1;
  assign fail_trip = (fail_inc >= MAX_FAIL_C);

  doorlock_pw_cmp u_pw_cmp (
    .entry  (entry_buf),
    .stored (stored_pw),
    .match  (pw_match)
  );

  // Main controller: state, entry buffer, stored code, timer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      entry_buf   <= '0;
      stored_pw   <= DEFAULT_PW;
      timer       <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      digit_cnt   <= '0;
      fail_cnt    <= '0;
      change_mode <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (key_dig) begin
            state <= ENTRY;
            if (!buf_full) begin
              entry_buf <= {entry_buf[11:0], key_code};
              digit_cnt <= digit_cnt + DIGIT_CNT_W'(1);
            end
          end else if (key_clr) begin
            entry_buf   <= '0;
            digit_cnt   <= '0;
            change_mode <= 1'b0;
            state       <= IDLE;
          end else if (key_ent) begin
            if (buf_full) begin
              state <= CHECK;
            end else begin
              // Short entry counts as a failed attempt.
              entry_buf <= '0;
              digit_cnt <= '0;
              err_pulse <= 1'b1;
              fail_cnt  <= fail_inc;
              if (fail_trip) begin
                state      <= LOCKOUT;
                locked_out <= 1'b1;
                timer      <= LOCKOUT_LOAD;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        CHECK: begin
          entry_buf <= '0;
          digit_cnt <= '0;
          if (pw_match) begin
            fail_cnt <= '0;
            unlocked <= 1'b1;
            timer    <= UNLOCK_LOAD;
            state    <= OPEN;
          end else begin
            err_pulse <= 1'b1;
            fail_cnt  <= fail_inc;
            if (fail_trip) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
              timer      <= LOCKOUT_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        OPEN: begin
          if (key_chg) begin
            unlocked    <= 1'b0;
            change_mode <= 1'b1;
            entry_buf   <= '0;
            digit_cnt   <= '0;
            timer       <= '0;
            state       <= NEWPW;
          end else if (timer == '0) begin
            unlocked <= 1'b0;
            state    <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        NEWPW: begin
          if (key_dig) begin
            if (!buf_full) begin
              entry_buf <= {entry_buf[11:0], key_code};
              digit_cnt <= digit_cnt + DIGIT_CNT_W'(1);
            end
          end else if (key_clr) begin
            entry_buf   <= '0;
            digit_cnt   <= '0;
            change_mode <= 1'b0;
            state       <= IDLE;
          end else if (key_ent) begin
            entry_buf <= '0;
            digit_cnt <= '0;
            if (buf_full) begin
              stored_pw   <= entry_buf;
              change_mode <= 1'b0;
              state       <= IDLE;
            end else begin
              // Short new code is rejected but is not a failed unlock attempt.
              err_pulse <= 1'b1;
            end
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            state      <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Self-checking bench for doorlock_ctrl: vector table, corner sequences, randomized model run.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_doorlock_ctrl;
  import doorlock_pkg::*;

  localparam int UNLOCK  = 20;
  localparam int LOCKOUT = 30;
  localparam int MAXF    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] digit_cnt;
  logic [2:0] fail_cnt;
  logic       change_mode;
  logic       err_pulse;
  logic [9:0] outs;

  doorlock_ctrl #(
    .UNLOCK_CYCLES  (UNLOCK),
    .LOCKOUT_CYCLES (LOCKOUT),
    .MAX_FAIL       (MAXF),
    .DEFAULT_PW     (16'h1234)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt),
    .change_mode (change_mode),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  assign outs = {unlocked, locked_out, digit_cnt, fail_cnt, change_mode, err_pulse};

  int vectors     = 0;
  int miscompares = 0;
  int errs_seen   = 0;

  typedef struct {
    bit         kv;
    logic [3:0] kc;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Output pack order: unlocked, locked_out, digit_cnt, fail_cnt, change_mode, err_pulse.
  function automatic logic [9:0] ex(bit u, bit lo, int dc, int fc, bit cm, bit ep);
    return {u, lo, 3'(dc), 3'(fc), cm, ep};
  endfunction

  task automatic add(input bit kv, input logic [3:0] kc, input logic [9:0] e);
    tbl.push_back('{kv, kc, e});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock with the given key, outputs left ready for sampling 1ns after the edge.
  task automatic step(input bit kv, input logic [3:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    if (err_pulse) errs_seen++;
  endtask

  task automatic enter_code(input logic [3:0] a, b, c, d);
    step(1, a); step(1, b); step(1, c); step(1, d); step(1, KEY_ENTER);
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any clock edge.
  task automatic async_rst(input string name);
    #2;
    rst = 1'b1;
    #1;
    check(name, outs, 10'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_digits[$];
  int m_code[4];
  int m_fails, m_open, m_lock;
  bit m_chg, m_chk, m_err;

  task automatic model_reset();
    m_digits.delete();
    m_code = '{1, 2, 3, 4};
    m_fails = 0; m_open = 0; m_lock = 0;
    m_chg = 0; m_chk = 0; m_err = 0;
  endtask

  task automatic model_fail();
    m_err = 1;
    m_fails++;
    if (m_fails >= MAXF) m_lock = LOCKOUT;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc);
    bit ok;
    ok = 1;
    m_err = 0;
    if (m_chk) begin
      for (int i = 0; i < 4; i++) if (m_digits[i] != m_code[i]) ok = 0;
      m_chk = 0;
      m_digits.delete();
      if (ok) begin m_fails = 0; m_open = UNLOCK; end
      else model_fail();
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_open > 0) begin
      if (kv && kc == KEY_CHANGE) begin
        m_open = 0; m_chg = 1; m_digits.delete();
      end else m_open--;
    end else if (kv) begin
      if (kc <= 4'd9) begin
        if (m_digits.size() < 4) m_digits.push_back(int'(kc));
      end else if (kc == KEY_CLEAR) begin
        m_digits.delete(); m_chg = 0;
      end else if (kc == KEY_ENTER) begin
        if (m_digits.size() == 4) begin
          if (m_chg) begin
            for (int i = 0; i < 4; i++) m_code[i] = m_digits[i];
            m_chg = 0;
            m_digits.delete();
          end else m_chk = 1;
        end else begin
          m_digits.delete();
          if (m_chg) m_err = 1;
          else model_fail();
        end
      end
    end
  endtask

  function automatic logic [9:0] m_exp();
    return {(m_open > 0), (m_lock > 0), 3'(m_digits.size()), 3'(m_fails), m_chg, m_err};
  endfunction

  logic [3:0] lk_keys [5] = '{4'd1, 4'd2, 4'd3, 4'd4, KEY_ENTER};

  initial begin
    int first, cnt, lo_cnt;
    bit bad;
    bit kv;
    logic [3:0] kc;
    int r;

    // ---- reset state ----
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    #1;
    check("reset_async", outs, 10'd0);
    @(posedge clk);
    #1;
    check("reset_held", outs, 10'd0);
    rst = 1'b0;

    // ---- vector table: boundaries, open-state key filtering, code change, failures ----
    add(1, 4'd1, ex(0,0,1,0,0,0));
    add(1, 4'd2, ex(0,0,2,0,0,0));
    add(1, KEY_CLEAR, ex(0,0,0,0,0,0));
    add(1, 4'd1, ex(0,0,1,0,0,0));
    add(1, 4'd2, ex(0,0,2,0,0,0));
    add(1, 4'd3, ex(0,0,3,0,0,0));
    add(1, 4'd4, ex(0,0,4,0,0,0));
    add(1, 4'd5, ex(0,0,4,0,0,0));
    add(1, KEY_ENTER, ex(0,0,4,0,0,0));
    add(0, 4'd0, ex(1,0,0,0,0,0));
    add(1, 4'd7, ex(1,0,0,0,0,0));
    add(1, KEY_CLEAR, ex(1,0,0,0,0,0));
    add(1, KEY_ENTER, ex(1,0,0,0,0,0));
    add(1, KEY_CHANGE, ex(0,0,0,0,1,0));
    add(1, 4'd5, ex(0,0,1,0,1,0));
    add(1, 4'd6, ex(0,0,2,0,1,0));
    add(1, KEY_ENTER, ex(0,0,0,0,1,1));
    add(1, 4'd5, ex(0,0,1,0,1,0));
    add(1, 4'd6, ex(0,0,2,0,1,0));
    add(1, 4'd7, ex(0,0,3,0,1,0));
    add(1, 4'd8, ex(0,0,4,0,1,0));
    add(1, KEY_ENTER, ex(0,0,0,0,0,0));
    add(1, KEY_CHANGE, ex(0,0,0,0,0,0));
    add(1, 4'd1, ex(0,0,1,0,0,0));
    add(1, 4'd2, ex(0,0,2,0,0,0));
    add(1, KEY_ENTER, ex(0,0,0,1,0,1));
    add(0, 4'd0, ex(0,0,0,1,0,0));
    add(1, 4'd1, ex(0,0,1,1,0,0));
    add(1, 4'd2, ex(0,0,2,1,0,0));
    add(1, 4'd3, ex(0,0,3,1,0,0));
    add(1, 4'd4, ex(0,0,4,1,0,0));
    add(1, KEY_ENTER, ex(0,0,4,1,0,0));
    add(1, 4'd9, ex(0,0,0,2,0,1));
    add(0, 4'd0, ex(0,0,0,2,0,0));
    add(1, 4'hE, ex(0,0,0,2,0,0));
    add(1, 4'd5, ex(0,0,1,2,0,0));
    add(1, 4'd6, ex(0,0,2,2,0,0));
    add(1, 4'd7, ex(0,0,3,2,0,0));
    add(1, 4'd8, ex(0,0,4,2,0,0));
    add(1, KEY_ENTER, ex(0,0,4,2,0,0));
    add(0, 4'd0, ex(1,0,0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].kv, tbl[i].kc);
      check($sformatf("tbl[%0d]", i), outs, tbl[i].exp);
    end

    // ---- unlock window length ----
    do_reset();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    first = -1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 4'd0);
      if (unlocked) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    check("unlock_first_cycle", first, 0);
    check("unlock_cycles", cnt, UNLOCK);
    check("unlock_end_outs", outs, 10'd0);

    // ---- lockout after MAX_FAIL wrong codes ----
    do_reset();
    errs_seen = 0;
    for (int rr = 0; rr < 3; rr++) begin
      enter_code(4'd9, 4'd9, 4'd9, 4'd9);
      step(0, 4'd0);
      check($sformatf("wrong_code_%0d", rr), outs, ex(0, (rr == 2), 0, rr + 1, 0, 1));
    end
    lo_cnt = locked_out ? 1 : 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(locked_out, lk_keys[i % 5]);
      if (locked_out) lo_cnt++;
      if (digit_cnt != 3'd0 || unlocked) bad = 1;
    end
    check("lockout_err_pulses", errs_seen, 3);
    check("lockout_cycles", lo_cnt, LOCKOUT);
    check("lockout_keys_ignored", bad, 0);
    check("lockout_end_outs", outs, 10'd0);

    // ---- asynchronous reset mid-OPEN and mid-NEWPW ----
    do_reset();
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    step(0, 4'd0); step(0, 4'd0); step(0, 4'd0);
    check("pre_rst_open", outs, ex(1,0,0,0,0,0));
    async_rst("rst_mid_open");
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    step(0, 4'd0);
    step(1, KEY_CHANGE);
    step(1, 4'd5);
    step(1, 4'd6);
    check("pre_rst_newpw", outs, ex(0,0,2,0,1,0));
    async_rst("rst_mid_newpw");
    enter_code(4'd5, 4'd6, 4'd7, 4'd8);
    step(0, 4'd0);
    check("after_rst_newcode_rejected", outs, ex(0,0,0,1,0,1));
    enter_code(4'd1, 4'd2, 4'd3, 4'd4);
    step(0, 4'd0);
    check("after_rst_default_unlocks", outs, ex(1,0,0,0,0,0));

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check($sformatf("rnd_rst[%0d]", n), outs, m_exp());
        #2;
        rst = 1'b0;
      end
      kv = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 15));
      if (r < 8)       kc = (m_digits.size() < 4) ? 4'(m_code[m_digits.size()]) : 4'($urandom_range(0, 9));
      else if (r < 10) kc = KEY_ENTER;
      else if (r == 10) kc = KEY_CLEAR;
      else if (r == 11) kc = KEY_CHANGE;
      else if (r < 14) kc = 4'($urandom_range(0, 9));
      else             kc = 4'($urandom_range(0, 15));
      step(kv, kc);
      model_step(kv, kc);
      check($sformatf("rnd[%0d]", n), outs, m_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

endmodule
